// File: rtl/instr_mem_loader.sv
// instr_mem_loader: program memory filled over a valid/ready stream, then
// read by the fetch stage with RD_LAT-cycle latency and range checking.
//
// Parameters:
//   DEPTH     memory size in 32-bit words (power of two, 16..4096)
//   ADDR_W    width of pc (must exceed log2(DEPTH)+2)
//   RD_LAT    fetch latency in cycles (1..4)
//   NOP_INSTR word returned for invalid or absent instructions
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load_valid/ready stream handshake for program words
//   load_data        program word
//   load_last        marks the final word of the image
//   reload           reload request (only with INSTR_MEM_RELOAD_EN)
//   instr_rd_en, pc  fetch request and byte address
//   instr            fetched word, held while instr_valid is low
//   instr_valid      instr belongs to a completed fetch
//   addr_err         completed fetch was misaligned or out of range
//   busy             image is being loaded; fetches are ignored
//   load_count       number of words in the current image
//
// Optional feature: define INSTR_MEM_RELOAD_EN to let `reload` return the
// block to LOAD from RUN (flushing in-flight fetches) or restart a load.
// Without it `reload` is ignored and only `rst` leaves RUN.

module instr_mem_loader #(
   parameter int          DEPTH     = 256,
   parameter int          ADDR_W    = 32,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   input  logic [31:0]            load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   reload,
   input  logic                   instr_rd_en,
   input  logic [ADDR_W-1:0]      pc,
   output logic [31:0]            instr,
   output logic                   instr_valid,
   output logic                   addr_err,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] load_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   typedef enum logic {
      S_LOAD,
      S_RUN
   } state_t;

   state_t state;
   state_t state_nxt;

   // Write index doubles as the word count of the image.
   logic [CNT_W-1:0]  wr_idx;
   logic [31:0]       mem [DEPTH];

   logic              reload_req;
   logic              hs;
   logic              last_word;
   logic              fire;
   logic              fetch_ok;
   logic [IDX_W-1:0]  rd_idx;
   logic [ADDR_W-1:0] word_addr;

   // Fetch pipeline; stage RD_LAT-1 drives the outputs.
   logic [RD_LAT-1:0] p_v;
   logic [RD_LAT-1:0] p_e;
   logic [31:0]       p_d [RD_LAT];

`ifdef INSTR_MEM_RELOAD_EN
   assign reload_req = reload;
`else
   logic unused_reload;
   assign unused_reload = reload;
   assign reload_req    = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_LOAD: begin
            if (reload_req) begin
               state_nxt = S_LOAD;
            end else if (hs && (load_last || last_word)) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (reload_req) begin
               state_nxt = S_LOAD;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy       = 1'b0;
      load_ready = 1'b0;
      unique case (state)
         S_LOAD: begin
            busy       = 1'b1;
            load_ready = (wr_idx < CNT_W'(DEPTH));
         end
         S_RUN: begin
            busy       = 1'b0;
            load_ready = 1'b0;
         end
         default: begin
            busy       = 1'b1;
            load_ready = 1'b0;
         end
      endcase
   end

   // A reload request in the same cycle wins over a load word.
   assign hs        = load_valid & load_ready & ~reload_req & ~rst;
   assign last_word = (wr_idx == CNT_W'(DEPTH - 1));

   // ---------------- write index / count ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
      end else if (reload_req) begin
         wr_idx <= '0;
      end else if (hs) begin
         wr_idx <= wr_idx + CNT_W'(1);
      end
   end

   assign load_count = wr_idx;

   // Storage is deliberately not reset; wr_idx bounds what is valid.
   always_ff @(posedge clk) begin
      if (hs) begin
         mem[wr_idx[IDX_W-1:0]] <= load_data;
      end
   end

   // ---------------- fetch ----------------
   assign word_addr = pc >> 2;
   assign rd_idx    = pc[IDX_W+1:2];
   assign fetch_ok  = (pc[1:0] == 2'b00) &&
                      (word_addr < ADDR_W'(wr_idx));
   assign fire      = instr_rd_en & (state == S_RUN) & ~reload_req;

   always_ff @(posedge clk) begin
      if (rst || reload_req) begin
         p_v <= '0;
         p_e <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            p_d[k] <= NOP_INSTR;
         end
      end else begin
         p_v[0] <= fire;
         p_e[0] <= fire & ~fetch_ok;
         if (fire) begin
            p_d[0] <= fetch_ok ? mem[rd_idx] : NOP_INSTR;
         end
         // Data only advances with a valid token so instr holds.
         for (int k = 1; k < RD_LAT; k++) begin
            p_v[k] <= p_v[k-1];
            p_e[k] <= p_e[k-1];
            if (p_v[k-1]) begin
               p_d[k] <= p_d[k-1];
            end
         end
      end
   end

   assign instr       = p_d[RD_LAT-1];
   assign instr_valid = p_v[RD_LAT-1];
   assign addr_err    = p_e[RD_LAT-1];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (DEPTH=16, RD_LAT=3).
// Expected fetch results are queued at issue; a monitor checks them.

module tb_instr_mem_loader;

   localparam int          DEPTH  = 16;
   localparam int          ADDR_W = 32;
   localparam int          RD_LAT = 3;
   localparam logic [31:0] NOP    = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        reload = 1'b0;
   logic        instr_rd_en = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        addr_err;
   logic        busy;
   logic [4:0]  load_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          c;
   } exp_t;

   exp_t q[$];
   exp_t m_e;

   instr_mem_loader #(
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT),
      .NOP_INSTR(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .reload(reload),
      .instr_rd_en(instr_rd_en),
      .pc(pc),
      .instr(instr),
      .instr_valid(instr_valid),
      .addr_err(addr_err),
      .busy(busy),
      .load_count(load_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: every valid output must match the oldest expected entry.
   always @(negedge clk) begin
      if (instr_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: instr=%h err=%b cyc=%0d",
                     instr, addr_err, cyc);
         end else begin
            m_e = q.pop_front();
            if (instr !== m_e.d || addr_err !== m_e.e ||
                cyc != m_e.c + RD_LAT) begin
               errors++;
               $display("FAIL fetch: got %h/err%b @%0d expected %h/err%b @%0d",
                        instr, addr_err, cyc, m_e.d, m_e.e, m_e.c + RD_LAT);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] d, logic e);
      exp_t x;
      x.d = d;
      x.e = e;
      x.c = cyc;
      q.push_back(x);
      pc = a;
      instr_rd_en = 1'b1;
      tick();
   endtask

   task automatic load_word(logic [31:0] d, logic last);
      load_valid = 1'b1;
      load_data = d;
      load_last = last;
      tick();
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic drain(string name);
      instr_rd_en = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d fetches still pending, expected 0",
                  name, q.size());
         q.delete();
      end
      repeat (4) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_instr", instr, NOP);
      chk("rst_valid", {31'b0, instr_valid}, 0);
      chk("rst_err", {31'b0, addr_err}, 0);
      chk("rst_busy", {31'b0, busy}, 1);
      chk("rst_ready", {31'b0, load_ready}, 1);
      chk("rst_count", {27'b0, load_count}, 0);
      rst = 1'b0;
      tick();

      // 4-word image; fetch requests during LOAD are ignored
      instr_rd_en = 1'b1;
      load_word(32'h0140_0193, 1'b0);
      load_word(32'h0050_0213, 1'b0);
      instr_rd_en = 1'b0;
      chk("cnt_after2", {27'b0, load_count}, 2);
      load_word(32'h0042_12B3, 1'b0);
      chk("busy_before_last", {31'b0, busy}, 1);
      load_word(32'h0480_0113, 1'b1);
      chk("busy_after_last", {31'b0, busy}, 0);
      chk("ready_run", {31'b0, load_ready}, 0);
      chk("cnt_4", {27'b0, load_count}, 4);

      // Back-to-back fetches launched right after entering RUN
      issue(32'h0, 32'h0140_0193, 1'b0);
      issue(32'h4, 32'h0050_0213, 1'b0);
      issue(32'h8, 32'h0042_12B3, 1'b0);
      issue(32'hC, 32'h0480_0113, 1'b0);
      drain("b2b");

      // Out-of-range and misaligned, then a good fetch to test hold
      issue(32'h10, NOP, 1'b1);
      issue(32'h6, NOP, 1'b1);
      issue(32'h8, 32'h0042_12B3, 1'b0);
      drain("bad_addr");
      chk("hold_instr", instr, 32'h0042_12B3);
      chk("hold_err", {31'b0, addr_err}, 0);

      // Reset two cycles after a fetch: no valid may emerge
      pc = 32'h0;
      instr_rd_en = 1'b1;
      tick();
      instr_rd_en = 1'b0;
      rst = 1'b1;
      load_valid = 1'b1;
      load_data = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      load_valid = 1'b0;
      chk("midrst_busy", {31'b0, busy}, 1);
      chk("midrst_count", {27'b0, load_count}, 0);
      chk("midrst_instr", instr, NOP);
      repeat (5) tick();
      chk("midrst_count2", {27'b0, load_count}, 0);

      // Overflow: 17 words without last into a 16-word memory
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("ovf_ready%0d", i), {31'b0, load_ready},
             (i < 16) ? 32'd1 : 32'd0);
         load_word(32'hA000_0000 + i, 1'b0);
      end
      chk("ovf_count", {27'b0, load_count}, 16);
      chk("ovf_busy", {31'b0, busy}, 0);
      issue(32'h3C, 32'hA000_000F, 1'b0);
      issue(32'h40, NOP, 1'b1);
      issue(32'h0, 32'hA000_0000, 1'b0);
      drain("ovf_fetch");

`ifdef INSTR_MEM_RELOAD_EN
      // Reload while a fetch is in flight, then a 2-word image
      pc = 32'h4;
      instr_rd_en = 1'b1;
      tick();
      instr_rd_en = 1'b0;
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("reload_busy", {31'b0, busy}, 1);
      chk("reload_count", {27'b0, load_count}, 0);
      chk("reload_instr", instr, NOP);
`else
      // Reload is ignored in this build
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("noreload_busy", {31'b0, busy}, 0);
      chk("noreload_count", {27'b0, load_count}, 16);
      issue(32'h4, 32'hA000_0001, 1'b0);
      drain("noreload_fetch");
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      load_word(32'h1111_1111, 1'b0);
      load_word(32'h2222_2222, 1'b1);
      chk("img2_busy", {31'b0, busy}, 0);
      chk("img2_count", {27'b0, load_count}, 2);
      issue(32'h0, 32'h1111_1111, 1'b0);
      issue(32'h4, 32'h2222_2222, 1'b0);
      issue(32'h8, NOP, 1'b1);
      issue(32'hC, NOP, 1'b1);
      drain("img2_fetch");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, synthesizable instruction memory with a streaming load port. It replaces hand-timed instruction stimulus driven into `rv_core`. After reset it accepts a program image word by word over a valid/ready port. It then serves instructions to the core's fetch stage on `pc`/`instr_rd_en` with a configurable read latency, a valid flag, and out-of-range protection. It sits between the program source (bench or boot SPI path) and the core's `instr` input.

## Interface
- `DEPTH`, 256 — memory size in 32-bit words; power of two, 16..4096.
- `ADDR_W`, 32 — width of `pc`.
- `RD_LAT`, 1 — fetch latency in cycles, 1..4.
- `NOP_INSTR`, 32'h0000_0033 — word returned when no valid instruction exists (`add x0,x0,x0`).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `load_valid`  in  1  — load word present.
- `load_data`  in  32  — program word.
- `load_last`  in  1  — qualifies the final word of the image.
- `load_ready`  out  1  — block accepts a load word this cycle.
- `reload`  in  1  — single-cycle request to reload the image (see Configuration).
- `instr_rd_en`  in  1  — fetch request from the core.
- `pc`  in  ADDR_W  — byte address of the fetch.
- `instr`  out  32  — fetched instruction.
- `instr_valid`  out  1  — `instr` corresponds to a completed fetch.
- `addr_err`  out  1  — completed fetch was misaligned or out of range.
- `busy`  out  1  — block is in LOAD; the core must hold fetch.
- `load_count`  out  log2(DEPTH)+1  — number of words loaded.

## Operation
- FSM states: LOAD and RUN. Reset enters LOAD.
- **LOAD**
  - `load_ready`=1 while `wr_idx` < DEPTH.
  - A handshake (`load_valid`&`load_ready`) writes `load_data` to `mem[wr_idx]`, then increments `wr_idx` and `load_count`.
  - `load_last` on a handshake moves the FSM to RUN on the next cycle.
  - Writing word DEPTH-1 without `load_last` also moves the FSM to RUN; `load_ready` drops the same cycle.
  - `instr_rd_en` is ignored. `instr`=NOP_INSTR, `instr_valid`=0, `busy`=1.
- **RUN**
  - `load_ready`=0 and `busy`=0.
  - Each `instr_rd_en` launches a fetch of word `pc[log2(DEPTH)+1:2]`.
  - The fetch result is valid only if `pc[1:0]`==0 and `pc>>2` < `load_count`.
  - A valid fetch returns the stored word. An invalid fetch returns NOP_INSTR with `addr_err`=1.
  - Words at or beyond `load_count` read as NOP_INSTR, never stale contents.
- Back-to-back fetches are fully pipelined: one per cycle.
- Memory contents are not cleared by `rst`; `load_count` is the sole validity bound.

## Timing
- Reset values: `instr`=NOP_INSTR, `instr_valid`=0, `addr_err`=0, `busy`=1, `load_ready`=1, `load_count`=0. Pipeline is flushed.
- Fetch latency: `instr_rd_en` sampled high in cycle N gives `instr_valid`=1 in cycle N+RD_LAT. `instr` and `addr_err` are registered alongside it.
- `instr` holds its last value when `instr_valid`=0 in RUN.
- Load-to-run: a handshake with `load_last` in cycle N gives `busy`=0 in cycle N+1. A fetch may launch in N+1.
- `rst` mid-operation: on the next edge all of the following happen — pipeline cleared, FSM in LOAD, `wr_idx`=0, `load_count`=0.
- If `load_valid` and `rst` are both high, the word is not written.

## Configuration
- `INSTR_MEM_RELOAD_EN` defined:
  - `reload` high in RUN forces LOAD on the next edge. `wr_idx` and `load_count` clear, and in-flight fetches are flushed (no `instr_valid` from them).
  - `reload` in LOAD restarts the write index at 0.
- `INSTR_MEM_RELOAD_EN` undefined: `reload` is ignored, and leaving RUN requires `rst`.

## Test plan
- Reset, load 4 words (0x01400193, 0x00500213, 0x004212B3, 0x04800113 with last) → `busy` falls 1 cycle after last. With RD_LAT=1, fetching `pc`=0x8 gives `instr`=0x004212B3 and `instr_valid`=1 one cycle later.
- Back-to-back fetches of `pc`=0,4,8,C with RD_LAT=3 → four consecutive valid words starting 3 cycles after the first request.
- Fetch `pc`=0x10 after a 4-word load, then `pc`=0x6 → both return 0x00000033 with `addr_err`=1.
- DEPTH=16: stream 17 words without last → `load_ready`=0 after word 16, RUN entered, `load_count`=16, word 17 not accepted.
- Assert `rst` two cycles after a fetch is issued with RD_LAT=2 → no `instr_valid` pulse, `busy`=1, `load_count`=0.
- With `INSTR_MEM_RELOAD_EN`: pulse `reload` during an in-flight fetch, then load a 2-word image → no stale valid, new words fetched, and `pc`=0x8 gives `addr_err`.
